// File: rtl/controle_iluminacao.sv
// Lamp controller: AUTO mode follows the presence sensor with an off-timer, MANUAL mode toggles on button B.
// Optional macro PRESENCE_SYNC_EN inserts a 2-flop synchronizer on infra.
module controle_iluminacao #(
  parameter int AUTO_OFF_T = 30000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic infra,
  output logic lamp,
  output logic modo
);

  typedef enum logic [1:0] {
    AUTO_OFF = 2'b00,
    AUTO_ON  = 2'b01,
    MAN_OFF  = 2'b10,
    MAN_ON   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_OFF_T - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] cont, next_cont;
  logic             next_lamp, next_modo;
  logic             presence;

`ifdef PRESENCE_SYNC_EN
  logic sync_1, sync_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= infra;
      sync_2 <= sync_1;
    end
  end

  assign presence = sync_2;
`else
  assign presence = infra;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= AUTO_OFF;
      cont  <= '0;
      lamp  <= 1'b0;
      modo  <= 1'b0;
    end else begin
      state <= next_state;
      cont  <= next_cont;
      lamp  <= next_lamp;
      modo  <= next_modo;
    end
  end

  // A outranks B, which outranks the sensor/timer path
  always_comb begin
    next_state = state;
    next_cont  = cont;
    next_lamp  = 1'b0;
    next_modo  = 1'b0;
    case (state)
      AUTO_OFF: begin
        if (A) begin
          next_state = MAN_OFF;
        end else if (presence) begin
          next_state = AUTO_ON;
          next_cont  = '0;
        end
      end
      AUTO_ON: begin
        if (A) begin
          next_state = MAN_ON;
          next_cont  = '0;
        end else if (presence) begin
          next_cont = '0;
        end else if (cont == CNT_LAST) begin
          next_state = AUTO_OFF;
          next_cont  = '0;
        end else begin
          next_cont = cont + 1'b1;
        end
      end
      MAN_OFF: begin
        if (A) begin
          next_state = AUTO_OFF;
          next_cont  = '0;
        end else if (B) begin
          next_state = MAN_ON;
        end
      end
      MAN_ON: begin
        if (A) begin
          next_state = AUTO_OFF;
          next_cont  = '0;
        end else if (B) begin
          next_state = MAN_OFF;
        end
      end
      default: begin
        next_state = AUTO_OFF;
        next_cont  = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so they register alongside it
    next_lamp = (next_state == AUTO_ON) || (next_state == MAN_ON);
    next_modo = (next_state == MAN_OFF) || (next_state == MAN_ON);
  end

endmodule

// File: tb/tb_controle_iluminacao.sv
// Self-checking bench for controle_iluminacao: behavioural model feeds a scoreboard queue of expected outputs.
// Compile with PRESENCE_SYNC_EN defined to exercise the synchronizer build; the model follows the same macro.
module tb_controle_iluminacao;

  localparam int T = 10;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic A     = 1'b0;
  logic B     = 1'b0;
  logic infra = 1'b0;
  logic lamp, modo;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  bit m_man, m_lamp, m_s1, m_s2;
  int m_cnt;

  controle_iluminacao #(.AUTO_OFF_T(T), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .infra(infra),
    .lamp (lamp),
    .modo (modo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_man  = 1'b0;
    m_lamp = 1'b0;
    m_cnt  = 0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_edge(input bit a, input bit b, input bit inf);
    bit pres;
`ifdef PRESENCE_SYNC_EN
    pres = m_s2;
    m_s2 = m_s1;
    m_s1 = inf;
`else
    pres = inf;
`endif
    if (a) begin
      if (m_man) m_lamp = 1'b0;
      m_man = ~m_man;
      m_cnt = 0;
    end else if (m_man) begin
      if (b) m_lamp = ~m_lamp;
    end else if (!m_lamp) begin
      if (pres) begin
        m_lamp = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      if (pres) m_cnt = 0;
      else if (m_cnt == T - 1) begin
        m_lamp = 1'b0;
        m_cnt  = 0;
      end else m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_lamp"}, lamp, e[1]);
      check({tag, "_modo"}, modo, e[0]);
    end
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit inf, input string tag);
    @(negedge clk);
    A     = a;
    B     = b;
    infra = inf;
    model_edge(a, b, inf);
    exp_q.push_back({m_lamp, m_man});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset asserted mid-cycle must clear outputs without waiting for an edge
  task automatic applyReset(input string tag);
    @(negedge clk);
    A     = 1'b0;
    B     = 1'b0;
    infra = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_async_lamp"}, lamp, 1'b0);
    check({tag, "_async_modo"}, modo, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("por_lamp", lamp, 1'b0);
    check("por_modo", modo, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-count while the lamp is on
    applyStimulus(0, 0, 1, "t1_on");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, "t1_count");
    applyReset("t1_rst");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, "t1_after");

    // Timeout, including the exact falling sample
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "t2_high");
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, "t2_low");

    // Retrigger at the 5th low sample
    applyStimulus(0, 0, 1, "t2r_high");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, "t2r_low");
    applyStimulus(0, 0, 1, "t2r_pulse");
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, "t2r_low2");

    // Auto to manual, B toggles, sensor ignored
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "t3_on");
    applyStimulus(1, 0, 0, "t3_a");
    applyStimulus(0, 1, 1, "t3_b1");
    applyStimulus(0, 0, 0, "t3_idle1");
    applyStimulus(0, 0, 1, "t3_idle2");
    applyStimulus(0, 1, 0, "t3_b2");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, i[0], "t3_hold");

    // Manual back to auto via AUTO_OFF
    applyStimulus(1, 0, 0, "t4_a");
    applyStimulus(0, 0, 0, "t4_idle");
    applyStimulus(0, 0, 1, "t4_rise");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "t4_high");

    // Leaving manual with infra already high
    applyStimulus(1, 0, 1, "t4b_a");
    applyStimulus(1, 0, 1, "t4b_back");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "t4b_high");

    // Simultaneous A and B, B in auto
    applyStimulus(1, 0, 0, "t5_a");
    applyStimulus(0, 1, 0, "t5_b_off");
    applyStimulus(1, 1, 0, "t5_ab");
    applyStimulus(0, 0, 0, "t5_settle");
    applyStimulus(0, 1, 0, "t5_b_autooff");
    applyStimulus(0, 0, 0, "t5_idle");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, "t5_on");
    applyStimulus(0, 1, 0, "t5_b_autoon");
    applyStimulus(1, 1, 0, "t5_ab_auto");
    applyStimulus(0, 1, 1, "t5_b_man");

    // A wins over infra in AUTO_OFF, then reset out of manual
    applyReset("t5_rst");
    applyStimulus(1, 0, 1, "t5_a_infra");
    applyStimulus(0, 1, 1, "t5_b_man2");
    applyReset("t5_rst_man");
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, "t5_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
